// File: rtl/simon_rng_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : simon_rng_fifo                                              |
// | Description : Galois-LFSR random value source with rejection sampling     |
// |               into 0..NUM_VALUES-1, buffered in a show-ahead FIFO and     |
// |               handed out over a valid/take handshake.                     |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module simon_rng_fifo #(
  parameter int                VALUE_W    = 2,
  parameter int                NUM_VALUES = 4,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter int                DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic                         seed_load_i,
  input  logic [LFSR_W-1:0]            seed_i,
  input  logic                         take_i,
  output logic                         valid_o,
  output logic [VALUE_W-1:0]           value_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // Full-level and acceptance bound, sized to avoid width mismatches.
  localparam logic [LW-1:0]      c_FULL_LEVEL = LW'(DEPTH);
  localparam logic [VALUE_W:0]   c_NUM_VALUES = (VALUE_W+1)'(NUM_VALUES);

  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [VALUE_W-1:0] mem_q [DEPTH];

  logic [VALUE_W-1:0] w_cand;
  logic [LFSR_W-1:0]  w_lfsr_next;
  logic               w_pop;
  logic               w_step;
  logic               w_push;

  // Candidate is the low bits of the LFSR; accept only if inside the range so
  // every legal value keeps equal probability.
  assign w_cand      = lfsr_q[VALUE_W-1:0];
  assign w_lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  // A seed load flushes the FIFO, so it also suppresses pop and push.
  assign w_pop  = take_i & valid_o & ~seed_load_i;
  assign w_step = enable_i & ~seed_load_i & ((level_q != c_FULL_LEVEL) | w_pop);
  assign w_push = w_step & ({1'b0, w_cand} < c_NUM_VALUES);

  assign valid_o = (level_q != '0);
  assign value_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Next-state for LFSR, pointers and occupancy; seed load has top priority.
  always_comb begin
    lfsr_d   = lfsr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (seed_load_i) begin
      // Zero seed would lock the LFSR up, so fall back to the default seed.
      lfsr_d   = (seed_i == '0) ? SEED : seed_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_step) begin
        lfsr_d = w_lfsr_next;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (w_push && !w_pop) begin
        level_d = level_q + 1'b1;
      end else if (w_pop && !w_push) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  // State registers for LFSR, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= SEED;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= w_cand;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_rng_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_simon_rng_fifo                                           |
// | Description : Self-checking bench for simon_rng_fifo: queue-based model   |
// |               compared every cycle plus directed literal expectations.    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_simon_rng_fifo;

  localparam logic [15:0] M_SEED = 16'hACE1;
  localparam logic [15:0] M_TAPS = 16'hB400;
  localparam int          M_DEPTH = 4;
  localparam int          M_NV    = 4;

  logic        clk;
  logic        rst_n;
  logic        enable, seed_load, take;
  logic [15:0] seed;
  logic        valid;
  logic [1:0]  value;
  logic [2:0]  level;

  logic        enable3, seed_load3, take3;
  logic [15:0] seed3;
  logic        valid3;
  logic [1:0]  value3;
  logic [2:0]  level3;

  int errors = 0;
  int checks = 0;
  bit mon_on = 0;

  simon_rng_fifo dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .seed_load_i(seed_load),
    .seed_i(seed), .take_i(take), .valid_o(valid), .value_o(value), .level_o(level)
  );

  simon_rng_fifo #(.NUM_VALUES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable3), .seed_load_i(seed_load3),
    .seed_i(seed3), .take_i(take3), .valid_o(valid3), .value_o(value3), .level_o(level3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: LFSR as an integer state, FIFO as a queue.
  logic [15:0] m_lfsr;
  int          mq[$];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? M_TAPS : 16'h0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit m_pop;
    bit m_step;
    int cand;
    if (!rst_n) begin
      m_lfsr <= M_SEED;
      mq.delete();
    end else if (seed_load) begin
      m_lfsr <= (seed == 16'h0) ? M_SEED : seed;
      mq.delete();
    end else begin
      m_pop  = take && (mq.size() != 0);
      m_step = enable && ((mq.size() < M_DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_step) begin
        cand = int'(m_lfsr) % 4;
        if (cand < M_NV) mq.push_back(cand);
        m_lfsr <= lfsr_adv(m_lfsr);
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      check("mdl_valid", 32'(valid), 32'(mq.size() != 0));
      check("mdl_level", 32'(level), 32'(mq.size()));
      if (mq.size() != 0) check("mdl_value", 32'(value), 32'(mq[0]));
    end
  end

  // From empty FIFO with lfsr=ACE1 and enable=1: fill 1,0,0,0, hold, then pop 5.
  task automatic run_seq(input string tag);
    int exp_pop[5] = '{1, 0, 0, 0, 2};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_fill_level"}, 32'(level), 32'(i + 1));
      check({tag, "_fill_head"}, 32'(value), 32'd1);
    end
    repeat (2) @(negedge clk);
    check({tag, "_hold_level"}, 32'(level), 32'd4);
    take = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check({tag, "_pop_valid"}, 32'(valid), 32'd1);
      check({tag, "_pop_value"}, 32'(value), 32'(exp_pop[i]));
      check({tag, "_pop_level_max"}, 32'(level <= 3'd4), 32'd1);
      @(negedge clk);
    end
    take = 1'b0;
  endtask

  initial begin
    int pops;
    int cycles;
    rst_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed = 16'h0; take = 1'b0;
    enable3 = 1'b0; seed_load3 = 1'b0; seed3 = 16'h0; take3 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_level3", 32'(level3), 32'd0);

    // Test 1 and 2: default fill then popping while refilling.
    rst_n = 1'b1; enable = 1'b1; mon_on = 1'b1;
    run_seq("t1");

    // Test 4: zero seed while full flushes and restores the default seed.
    repeat (2) @(negedge clk);
    check("t4_full", 32'(level), 32'd4);
    seed_load = 1'b1; seed = 16'h0;
    @(negedge clk);
    check("t4_flush_level", 32'(level), 32'd0);
    check("t4_flush_valid", 32'(valid), 32'd0);
    seed_load = 1'b0;
    run_seq("t4");

    // Test 5: asynchronous reset between clock edges, mid-fill.
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(valid), 32'd0);
    check("t5_async_level", 32'(level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq("t5");

    // Test 6: drain with enable low; LFSR must resume where it stopped (6162).
    @(negedge clk);
    check("t6_full", 32'(level), 32'd4);
    enable = 1'b0; take = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      check("t6_drain_level", 32'(level), 32'(i));
    end
    check("t6_empty_valid", 32'(valid), 32'd0);
    @(negedge clk);
    check("t6_take_ignored", 32'(level), 32'd0);
    take = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("t6_resume_level", 32'(level), 32'd1);
    check("t6_resume_value", 32'(value), 32'd2);
    repeat (5) @(negedge clk);
    take = 1'b1;
    repeat (8) @(negedge clk);
    take = 1'b0;
    repeat (2) @(negedge clk);

    // Test 3: NUM_VALUES=3 rejects candidate 3, then never emits 3.
    seed_load3 = 1'b1; seed3 = 16'h0003;
    @(negedge clk);
    seed_load3 = 1'b0; enable3 = 1'b1;
    check("t3_flush_level", 32'(level3), 32'd0);
    @(negedge clk);
    check("t3_reject_level", 32'(level3), 32'd0);
    @(negedge clk);
    check("t3_first_level", 32'(level3), 32'd1);
    check("t3_first_value", 32'(value3), 32'd1);
    take3 = 1'b1;
    pops = 0;
    cycles = 0;
    while (pops < 10000 && cycles < 30000) begin
      if (valid3) begin
        pops++;
        if (value3 == 2'd3) check("t3_no_three", 32'(value3), 32'd0);
      end
      @(negedge clk);
      cycles++;
    end
    check("t3_pop_count", 32'(pops >= 10000), 32'd1);
    take3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
